// File: rtl/rv32_mem_arbiter.sv
// Shares one memory bus between instruction fetch (IF) and load/store (LS).
// LS has priority, but IF is forced through after a bounded LS streak.
module rv32_mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] StreakMax = 4'(MAX_LS_STREAK);
  localparam logic [8:0] TmoLimit  = 9'(TIMEOUT_CYCLES);
  localparam bit         TmoEn     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StBusIf, StBusLs} state_e;

  state_e      state_q;
  logic [3:0]  streak_q;
  logic [7:0]  tmo_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        if_gnt_q, if_rvalid_q, if_err_q;
  logic        ls_gnt_q, ls_rvalid_q, ls_err_q;
  logic [31:0] if_rdata_q, ls_rdata_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;

  logic        ls_wins, ls_misal, ls_grant, if_grant, tmo_hit;
  logic [3:0]  ls_strb;
  logic [31:0] ls_wdat;

  always_comb begin
    ls_wins  = ls_req && !(if_req && (streak_q == StreakMax));
    ls_misal = 1'b0;
    ls_strb  = 4'b0000;
    ls_wdat  = ls_wdata;
    unique case (ls_size)
      2'b00: begin
        ls_strb = 4'b0001 << ls_addr[1:0];
        ls_wdat = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        ls_misal = ls_addr[0];
        ls_strb  = ls_addr[1] ? 4'b1100 : 4'b0011;
        ls_wdat  = {2{ls_wdata[15:0]}};
      end
      2'b10: begin
        ls_misal = |ls_addr[1:0];
        ls_strb  = 4'b1111;
      end
      default: ls_misal = 1'b1;
    endcase
    if (!ls_we) ls_strb = 4'b0000;
  end

  assign ls_grant = (state_q == StIdle) && ls_wins;
  assign if_grant = (state_q == StIdle) && !ls_wins && if_req;
  // Completion has priority: the limit only fires on a cycle without mem_ready.
  assign tmo_hit  = TmoEn && !mem_ready && (({1'b0, tmo_q} + 9'd1) == TmoLimit);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      tmo_q       <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;

      if (!if_req || if_grant) begin
        streak_q <= '0;
      end else if (ls_grant && (streak_q != StreakMax)) begin
        streak_q <= streak_q + 4'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (ls_wins) begin
            ls_gnt_q <= 1'b1;
            off_q    <= ls_addr[1:0];
            we_q     <= ls_we;
            if (ls_misal) begin
              ls_err_q <= 1'b1;
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {ls_addr[31:2], 2'b00};
              mem_wstrb_q <= ls_strb;
              mem_wdata_q <= ls_wdat;
              tmo_q       <= '0;
              state_q     <= StBusLs;
            end
          end else if (if_req) begin
            if_gnt_q    <= 1'b1;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {if_addr[31:2], 2'b00};
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            tmo_q       <= '0;
            state_q     <= StBusIf;
          end
        end
        StBusIf, StBusLs: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= StIdle;
            if (state_q == StBusIf) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= we_q ? 32'd0 : (mem_rdata >> {off_q, 3'b000});
            end
          end else if (tmo_hit) begin
            mem_valid_q <= 1'b0;
            state_q     <= StIdle;
            if (state_q == StBusIf) if_err_q <= 1'b1;
            else                    ls_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rv32_mem_arbiter;

  localparam int MaxStreak = 4;
  localparam int Tmo       = 16;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [1:0]  ls_size;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_valid;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  rv32_mem_arbiter #(.MAX_LS_STREAK(MaxStreak), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long it has held it, and the LS streak.
  logic        e_if_gnt, e_if_rvalid, e_if_err, e_ls_gnt, e_ls_rvalid, e_ls_err, e_mem_valid;
  logic [31:0] e_if_rdata, e_ls_rdata, e_mem_addr, e_mem_wdata;
  logic [3:0]  e_mem_wstrb;
  int          owner, streak, bus_cycles, m_nb, m_off;
  bit          m_store;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      {e_if_gnt, e_if_rvalid, e_if_err, e_ls_gnt, e_ls_rvalid, e_ls_err, e_mem_valid} = '0;
      e_if_rdata = 0; e_ls_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_wstrb = 0;
      owner = 0; streak = 0; bus_cycles = 0; m_off = 0; m_store = 0;
    end else begin
      {e_if_gnt, e_if_rvalid, e_if_err, e_ls_gnt, e_ls_rvalid, e_ls_err} = '0;
      if (owner == 0) begin
        if (ls_req && !(if_req && streak == MaxStreak)) begin
          e_ls_gnt = 1'b1;
          m_nb = (ls_size == 2'b00) ? 1 : (ls_size == 2'b01) ? 2 : 4;
          if (if_req) streak = (streak < MaxStreak) ? streak + 1 : streak;
          if (ls_size == 2'b11 || (ls_addr % m_nb) != 0) begin
            e_ls_err = 1'b1;
          end else begin
            owner = 2; bus_cycles = 0; e_mem_valid = 1'b1;
            e_mem_addr = ls_addr & 32'hFFFF_FFFC;
            m_off = int'(ls_addr % 4); m_store = ls_we;
            e_mem_wstrb = 0;
            if (ls_we) for (int b = 0; b < m_nb; b++) e_mem_wstrb[m_off + b] = 1'b1;
            for (int l = 0; l < 4; l++) e_mem_wdata[l*8 +: 8] = ls_wdata[(l % m_nb)*8 +: 8];
          end
        end else if (if_req) begin
          e_if_gnt = 1'b1; streak = 0; owner = 1; bus_cycles = 0; e_mem_valid = 1'b1;
          e_mem_addr = if_addr & 32'hFFFF_FFFC; e_mem_wstrb = 0; e_mem_wdata = 0;
        end
      end else begin
        bus_cycles++;
        if (mem_ready) begin
          e_mem_valid = 1'b0;
          if (owner == 1) begin
            e_if_rvalid = 1'b1; e_if_rdata = mem_rdata;
          end else begin
            e_ls_rvalid = 1'b1; e_ls_rdata = 0;
            if (!m_store)
              for (int b = 0; b < 4; b++)
                if (b + m_off < 4) e_ls_rdata[b*8 +: 8] = mem_rdata[(b + m_off)*8 +: 8];
          end
          owner = 0;
        end else if (Tmo != 0 && bus_cycles == Tmo) begin
          e_mem_valid = 1'b0;
          if (owner == 1) e_if_err = 1'b1; else e_ls_err = 1'b1;
          owner = 0;
        end
      end
      if (!if_req) streak = 0;
    end
  end

  int mv_total = 0;
  always @(negedge clk_i) begin
    if (mem_valid) mv_total++;
    if (chk_en) begin
      chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
      chk("if_err",    32'(if_err),    32'(e_if_err));
      chk("if_rdata",  if_rdata,       e_if_rdata);
      chk("ls_gnt",    32'(ls_gnt),    32'(e_ls_gnt));
      chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rvalid));
      chk("ls_err",    32'(ls_err),    32'(e_ls_err));
      chk("ls_rdata",  ls_rdata,       e_ls_rdata);
      chk("mem_valid", 32'(mem_valid), 32'(e_mem_valid));
      if (e_mem_valid) begin
        chk("mem_addr",  mem_addr,        e_mem_addr);
        chk("mem_wstrb", 32'(mem_wstrb),  32'(e_mem_wstrb));
        if (e_mem_wstrb != 0) chk("mem_wdata", mem_wdata, e_mem_wdata);
      end
    end
  end

  // Memory responder: mem_ready after resp_wait wait cycles, or never.
  int          resp_wait  = 2;
  bit          resp_never = 1'b0;
  logic [31:0] resp_data  = 32'h0;
  int          wait_cnt   = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    forever begin
      @(posedge clk_i); #1;
      if (mem_valid && !mem_ready) begin
        if (!resp_never && wait_cnt >= resp_wait) begin
          mem_ready = 1'b1; mem_rdata = resp_data; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        if (!mem_valid) wait_cnt = 0;
      end
    end
  end

  task automatic issue(input bit is_ls, input bit we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output int lat);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      if ((is_ls && ls_gnt) || (!is_ls && if_gnt)) begin
        lat = i;
        break;
      end
    end
    if (is_ls) ls_req = 1'b0; else if_req = 1'b0;
  endtask

  // ev: 1 if_rvalid, 2 if_err, 3 ls_rvalid, 4 ls_err, 0 none within budget
  task automatic wait_done(output int ev, output int cyc);
    ev = 0; cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_i); #1;
      if (if_rvalid) ev = 1;
      else if (if_err) ev = 2;
      else if (ls_rvalid) ev = 3;
      else if (ls_err) ev = 4;
      if (ev != 0) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  int lat, ev, cyc, mv0;
  int order[$];
  int exp_order[6] = '{2, 2, 2, 2, 1, 2};

  initial begin
    rst_n = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; ls_size = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);

    // IF fetch, two wait cycles
    resp_wait = 2; resp_data = 32'h0000_0013;
    issue(1'b0, 1'b0, 2'b00, 32'h100, 32'h0, lat);
    chk("if_gnt_latency", lat, 1);
    chk("if_mem_addr", mem_addr, 32'h100);
    chk("if_mem_wstrb", 32'(mem_wstrb), 32'h0);
    wait_done(ev, cyc);
    chk("if_done_event", ev, 1);
    chk("if_done_cycles", cyc, 3);
    chk("if_rdata_val", if_rdata, 32'h0000_0013);

    // Store byte at 0x203
    resp_wait = 1;
    issue(1'b1, 1'b1, 2'b00, 32'h203, 32'h0000_00AB, lat);
    chk("sb_gnt_latency", lat, 1);
    chk("sb_mem_addr", mem_addr, 32'h200);
    chk("sb_mem_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    wait_done(ev, cyc);
    chk("sb_done_event", ev, 3);
    chk("sb_rdata", ls_rdata, 32'h0);

    // Load half at 0x302
    resp_data = 32'hBEEF_1234;
    issue(1'b1, 1'b0, 2'b01, 32'h302, 32'h0, lat);
    chk("lh_mem_wstrb", 32'(mem_wstrb), 32'h0);
    wait_done(ev, cyc);
    chk("lh_done_event", ev, 3);
    chk("lh_rdata", ls_rdata, 32'h0000_BEEF);

    // Store half and word
    issue(1'b1, 1'b1, 2'b01, 32'h402, 32'h5555_1234, lat);
    chk("sh_mem_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'h1234_1234);
    wait_done(ev, cyc);
    issue(1'b1, 1'b1, 2'b10, 32'h404, 32'hCAFE_F00D, lat);
    chk("sw_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    wait_done(ev, cyc);

    // Misaligned word and illegal size: no bus cycle
    mv0 = mv_total;
    issue(1'b1, 1'b0, 2'b10, 32'h301, 32'h0, lat);
    chk("mis_gnt_latency", lat, 1);
    chk("mis_err", 32'(ls_err), 32'd1);
    issue(1'b1, 1'b1, 2'b11, 32'h400, 32'h0, lat);
    chk("ill_err", 32'(ls_err), 32'd1);
    repeat (3) @(posedge clk_i);
    #1 chk("mis_no_bus", mv_total - mv0, 0);

    // Fairness: both held continuously
    resp_wait = 0; order.delete();
    ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 32'h800; if_req = 1; if_addr = 32'h900;
    for (int i = 0; i < 200 && order.size() < 6; i++) begin
      @(posedge clk_i); #1;
      if (ls_gnt) order.push_back(2);
      if (if_gnt) order.push_back(1);
      if (order.size() >= 6) begin
        ls_req = 0; if_req = 0;
      end
    end
    ls_req = 0; if_req = 0;
    chk("fair_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("fair_order", order[i], exp_order[i]);
    repeat (5) @(posedge clk_i);

    // Timeout: mem_ready never comes
    #1 resp_never = 1'b1; mv0 = mv_total;
    issue(1'b0, 1'b0, 2'b00, 32'h500, 32'h0, lat);
    wait_done(ev, cyc);
    chk("tmo_event", ev, 2);
    chk("tmo_valid_cycles", mv_total - mv0, Tmo);
    resp_never = 1'b0; resp_wait = 1; resp_data = 32'h0000_0067;
    issue(1'b0, 1'b0, 2'b00, 32'h504, 32'h0, lat);
    wait_done(ev, cyc);
    chk("post_tmo_event", ev, 1);
    chk("post_tmo_rdata", if_rdata, 32'h0000_0067);

    // Reset mid-transaction
    resp_never = 1'b1;
    issue(1'b0, 1'b0, 2'b00, 32'h600, 32'h0, lat);
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b0;
    #2;
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_if_rdata", if_rdata, 32'd0);
    chk("mid_rst_if_err", 32'(if_err), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1; resp_never = 1'b0; resp_data = 32'h0000_0093;
    issue(1'b0, 1'b0, 2'b00, 32'h700, 32'h0, lat);
    chk("after_rst_gnt_latency", lat, 1);
    wait_done(ev, cyc);
    chk("after_rst_event", ev, 1);
    chk("after_rst_rdata", if_rdata, 32'h0000_0093);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Sequences and shares the single-port memory bus between instruction fetch (IF) and the execute unit's load/store path (LS).
- Arbitrates between the two requesters with bounded-starvation fixed priority.
- Generates byte strobes and lane-replicated write data; lane-aligns read data.
- Detects misaligned LS accesses and bus timeouts. Sits between the fetch/execute stages and the memory interface.

Parameters:
- MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is pending before IF is forced to win (1..15).
- TIMEOUT_CYCLES, 16, bus cycles with mem_valid high and no mem_ready before abort; 0 disables timeout (0..255).

Ports:
- clk_i  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  32  fetch address (word aligned by requester)
- if_gnt  out  1  one-cycle request-accepted pulse
- if_rvalid  out  1  one-cycle fetch data valid pulse
- if_rdata  out  32  fetch data, valid with if_rvalid
- if_err  out  1  one-cycle fetch timeout pulse
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, low-aligned
- ls_gnt  out  1  one-cycle accept pulse (also issued for misaligned requests)
- ls_rvalid  out  1  one-cycle completion pulse (load data or store ack)
- ls_rdata  out  32  load data shifted right by 8*addr[1:0]; 0 for stores
- ls_err  out  1  one-cycle misalign/illegal/timeout pulse
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion, sampled while mem_valid=1
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wstrb  out  4  byte strobes; 0000 = read
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, streak and timeout counters 0. Asserting reset mid-transaction drops mem_valid immediately; no rvalid or err is generated.
- States: IDLE, BUS_IF, BUS_LS. All outputs are registered.
- IDLE, cycle N with a request pending:
  - Select winner. LS wins unless IF is pending and streak==MAX_LS_STREAK.
  - Misaligned LS (half with addr[0]=1, word with addr[1:0]!=0, or size 11): ls_gnt and ls_err pulse at N+1. No bus cycle; stay IDLE.
  - Otherwise: at N+1 the winner's gnt pulses, mem_valid=1, and mem_addr/mem_wstrb/mem_wdata are loaded. Go to BUS_x.
- Streak counter:
  - Increments on each LS grant (including misaligned) while if_req=1; saturates at MAX_LS_STREAK.
  - Clears on an IF grant or when if_req=0.
- Strobes and write data:
  - Loads and IF use wstrb 0000.
  - Store byte: wstrb=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Store half: wstrb=addr[1]?1100:0011; wdata={2{wdata[15:0]}}.
  - Store word: wstrb 1111; wdata unchanged.
- BUS_x: mem_addr, mem_wstrb and mem_wdata stay stable while mem_valid=1.
  - mem_ready=1 at cycle M: mem_valid=0 at M+1. The owner's rvalid pulses at M+1 with rdata (LS load data shifted right by 8*addr[1:0]). Return to IDLE at M+1.
  - A new request is evaluated at M+1; its gnt follows at M+2, so back-to-back transfers leave exactly one idle bus cycle.
  - mem_ready is ignored while mem_valid=0.
- Timeout (TIMEOUT_CYCLES>0): the counter increments each BUS_x cycle without mem_ready and clears on entry to BUS_x. When the count reaches TIMEOUT_CYCLES, mem_valid drops next cycle, the owner's err pulses (no rvalid), and the state returns to IDLE. If mem_ready arrives on the same cycle the limit is reached, completion wins.
- Both requests first seen in the same cycle resolve per the priority rule; the loser keeps its request held and is served later.
- rdata outputs hold their last value between rvalid pulses.

Test Plan:
- IF-only: if_req, if_addr=0x100, mem_ready after 2 wait cycles with rdata=0x00000013 -> if_gnt 1 cycle after req, mem_addr=0x100, wstrb=0000, if_rvalid with 0x00000013 the cycle after mem_ready.
- Store byte: ls_addr=0x203, size=00, wdata=0xAB -> mem_addr=0x200, wstrb=1000, wdata=0xABABABAB, ls_rvalid ack with ls_rdata=0.
- Load half: addr=0x302, mem_rdata=0xBEEF1234 -> ls_rdata=0x0000BEEF. Misaligned word at 0x301 -> ls_gnt and ls_err pulse, mem_valid never asserted.
- Fairness (MAX_LS_STREAK=4): if_req and ls_req both held continuously -> grant order LS,LS,LS,LS,IF,LS...
- Timeout (TIMEOUT_CYCLES=16): mem_ready held 0 -> mem_valid high exactly 16 cycles, owner err pulse, no rvalid, next request is served normally.
- Reset asserted while mem_valid=1 -> all outputs 0 asynchronously; after release, state IDLE and a fresh IF request completes normally.
